// File: rtl/isdu.sv
// SLC-3 instruction sequencer/decode unit: Moore FSM stepping fetch, decode and
// execute, one microstate per clock, driving the datapath control word.
module isdu (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       IR_5,
   input  logic       BEN,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       LD_LED,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic       GateMARMUX,
   output logic       SR2MUX,
   output logic       ADDR1MUX,
   output logic       MARMUX,
   output logic       DRMUX,
   output logic       SR1MUX,
   output logic       MIO_EN,
   output logic [1:0] PCMUX,
   output logic [1:0] ADDR2MUX,
   output logic [1:0] ALUK,
   output logic       Mem_CE,
   output logic       Mem_UB,
   output logic       Mem_LB,
   output logic       Mem_OE,
   output logic       Mem_WE
);

   typedef enum logic [4:0] {
      HALTED, S_18, S_33_1, S_33_2, S_35, S_32,
      S_01, S_05, S_09, S_00, S_22, S_12, S_04, S_21,
      S_06, S_07, S_25_1, S_25_2, S_27, S_23, S_16_1, S_16_2,
      PAUSE_IR1, PAUSE_IR2
   } state_t;

   state_t r_state;
   state_t w_next;

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) r_state <= HALTED;
      else       r_state <= w_next;
   end

   // Next state and control word
   always_comb begin
      w_next     = r_state;
      LD_MAR     = 1'b0;
      LD_MDR     = 1'b0;
      LD_IR      = 1'b0;
      LD_BEN     = 1'b0;
      LD_CC      = 1'b0;
      LD_REG     = 1'b0;
      LD_PC      = 1'b0;
      LD_LED     = 1'b0;
      GatePC     = 1'b0;
      GateMDR    = 1'b0;
      GateALU    = 1'b0;
      GateMARMUX = 1'b0;
      SR2MUX     = 1'b0;
      ADDR1MUX   = 1'b0;
      MARMUX     = 1'b0;
      DRMUX      = 1'b0;
      SR1MUX     = 1'b0;
      MIO_EN     = 1'b0;
      PCMUX      = 2'b00;
      ADDR2MUX   = 2'b00;
      ALUK       = 2'b00;
      Mem_CE     = 1'b1;
      Mem_UB     = 1'b1;
      Mem_LB     = 1'b1;
      Mem_OE     = 1'b1;
      Mem_WE     = 1'b1;

      unique case (r_state)
         HALTED: if (Run) w_next = S_18;
         S_18: begin
            GatePC = 1'b1;
            LD_MAR = 1'b1;
            LD_PC  = 1'b1;
            w_next = S_33_1;
         end
         // Memory read: strobes held across both halves, MDR captures on the second
         S_33_1, S_33_2, S_25_1, S_25_2: begin
            Mem_CE = 1'b0;
            Mem_UB = 1'b0;
            Mem_LB = 1'b0;
            Mem_OE = 1'b0;
            MIO_EN = 1'b1;
            LD_MDR = (r_state == S_33_2) || (r_state == S_25_2);
            case (r_state)
               S_33_1:  w_next = S_33_2;
               S_33_2:  w_next = S_35;
               S_25_1:  w_next = S_25_2;
               default: w_next = S_27;
            endcase
         end
         S_35: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
            w_next  = S_32;
         end
         S_32: begin
            LD_BEN = 1'b1;
            case (Opcode)
               4'b0001: w_next = S_01;
               4'b0101: w_next = S_05;
               4'b1001: w_next = S_09;
               4'b0000: w_next = S_00;
               4'b1100: w_next = S_12;
               4'b0100: w_next = S_04;
               4'b0110: w_next = S_06;
               4'b0111: w_next = S_07;
               4'b1101: w_next = PAUSE_IR1;
               default: w_next = S_18;
            endcase
         end
         S_01, S_05: begin
            SR1MUX  = 1'b1;
            SR2MUX  = IR_5;
            ALUK    = (r_state == S_05) ? 2'b01 : 2'b00;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            w_next  = S_18;
         end
         S_09: begin
            SR1MUX  = 1'b1;
            ALUK    = 2'b10;
            GateALU = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            w_next  = S_18;
         end
         S_00: w_next = BEN ? S_22 : S_18;
         S_22: begin
            ADDR2MUX = 2'b10;
            PCMUX    = 2'b10;
            LD_PC    = 1'b1;
            w_next   = S_18;
         end
         S_12: begin
            SR1MUX  = 1'b1;
            ALUK    = 2'b11;
            GateALU = 1'b1;
            PCMUX   = 2'b01;
            LD_PC   = 1'b1;
            w_next  = S_18;
         end
         S_04: begin
            GatePC = 1'b1;
            DRMUX  = 1'b1;
            LD_REG = 1'b1;
            w_next = S_21;
         end
         S_21: begin
            ADDR2MUX = 2'b11;
            PCMUX    = 2'b10;
            LD_PC    = 1'b1;
            w_next   = S_18;
         end
         // Base+offset6 effective address into MAR for LDR/STR
         S_06, S_07: begin
            SR1MUX     = 1'b1;
            ADDR1MUX   = 1'b1;
            ADDR2MUX   = 2'b01;
            GateMARMUX = 1'b1;
            LD_MAR     = 1'b1;
            w_next     = (r_state == S_06) ? S_25_1 : S_23;
         end
         S_27: begin
            GateMDR = 1'b1;
            LD_REG  = 1'b1;
            LD_CC   = 1'b1;
            w_next  = S_18;
         end
         S_23: begin
            ALUK    = 2'b11;
            GateALU = 1'b1;
            LD_MDR  = 1'b1;
            w_next  = S_16_1;
         end
         S_16_1, S_16_2: begin
            Mem_CE = 1'b0;
            Mem_UB = 1'b0;
            Mem_LB = 1'b0;
            Mem_WE = 1'b0;
            w_next = (r_state == S_16_1) ? S_16_2 : S_18;
         end
         PAUSE_IR1: begin
            LD_LED = 1'b1;
            if (Continue) w_next = PAUSE_IR2;
         end
         PAUSE_IR2: if (!Continue) w_next = S_18;
         default: w_next = HALTED;
      endcase
   end

endmodule

// File: tb/tb_isdu.sv
// Table-driven, cycle-exact check of the isdu control word through every
// instruction flow, pause handshake and a reset in the middle of a load.
module tb_isdu;

   logic       Clk = 1'b0;
   logic       Reset, Run, Continue, IR_5, BEN;
   logic [3:0] Opcode;
   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
   logic       GatePC, GateMDR, GateALU, GateMARMUX;
   logic       SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN;
   logic [1:0] PCMUX, ADDR2MUX, ALUK;
   logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

   isdu dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
      .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN),
      .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
      .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
      .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
      .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MARMUX(MARMUX), .DRMUX(DRMUX),
      .SR1MUX(SR1MUX), .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
      .ALUK(ALUK), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
      .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
   );

   always #5 Clk = ~Clk;

   wire [28:0] w_out = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                        GatePC, GateMDR, GateALU, GateMARMUX,
                        SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX, MIO_EN,
                        PCMUX, ADDR2MUX, ALUK,
                        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

   // Field masks in w_out packing order
   localparam logic [28:0] B_LD_MAR  = 29'(1) << 28;
   localparam logic [28:0] B_LD_MDR  = 29'(1) << 27;
   localparam logic [28:0] B_LD_IR   = 29'(1) << 26;
   localparam logic [28:0] B_LD_BEN  = 29'(1) << 25;
   localparam logic [28:0] B_LD_CC   = 29'(1) << 24;
   localparam logic [28:0] B_LD_REG  = 29'(1) << 23;
   localparam logic [28:0] B_LD_PC   = 29'(1) << 22;
   localparam logic [28:0] B_LD_LED  = 29'(1) << 21;
   localparam logic [28:0] B_G_PC    = 29'(1) << 20;
   localparam logic [28:0] B_G_MDR   = 29'(1) << 19;
   localparam logic [28:0] B_G_ALU   = 29'(1) << 18;
   localparam logic [28:0] B_G_MARM  = 29'(1) << 17;
   localparam logic [28:0] B_SR2     = 29'(1) << 16;
   localparam logic [28:0] B_A1      = 29'(1) << 15;
   localparam logic [28:0] B_DR      = 29'(1) << 13;
   localparam logic [28:0] B_SR1     = 29'(1) << 12;
   localparam logic [28:0] B_MIO     = 29'(1) << 11;
   localparam logic [28:0] PCM_BUS   = 29'(1) << 9;
   localparam logic [28:0] PCM_ADR   = 29'(2) << 9;
   localparam logic [28:0] A2_6      = 29'(1) << 7;
   localparam logic [28:0] A2_9      = 29'(2) << 7;
   localparam logic [28:0] A2_11     = 29'(3) << 7;
   localparam logic [28:0] ALU_AND   = 29'(1) << 5;
   localparam logic [28:0] ALU_NOT   = 29'(2) << 5;
   localparam logic [28:0] ALU_PASS  = 29'(3) << 5;
   localparam logic [28:0] M_CE = 29'(1) << 4, M_UB = 29'(1) << 3, M_LB = 29'(1) << 2;
   localparam logic [28:0] M_OE = 29'(1) << 1, M_WE = 29'(1);

   // Expected control words per microstate
   localparam logic [28:0] DEF   = M_CE | M_UB | M_LB | M_OE | M_WE;
   localparam logic [28:0] E_18  = DEF | B_G_PC | B_LD_MAR | B_LD_PC;
   localparam logic [28:0] E_RD1 = M_WE | B_MIO;
   localparam logic [28:0] E_RD2 = M_WE | B_MIO | B_LD_MDR;
   localparam logic [28:0] E_35  = DEF | B_G_MDR | B_LD_IR;
   localparam logic [28:0] E_32  = DEF | B_LD_BEN;
   localparam logic [28:0] E_01  = DEF | B_SR1 | B_G_ALU | B_LD_REG | B_LD_CC;
   localparam logic [28:0] E_05  = E_01 | ALU_AND;
   localparam logic [28:0] E_09  = DEF | B_SR1 | ALU_NOT | B_G_ALU | B_LD_REG | B_LD_CC;
   localparam logic [28:0] E_22  = DEF | A2_9 | PCM_ADR | B_LD_PC;
   localparam logic [28:0] E_12  = DEF | B_SR1 | ALU_PASS | B_G_ALU | PCM_BUS | B_LD_PC;
   localparam logic [28:0] E_04  = DEF | B_G_PC | B_DR | B_LD_REG;
   localparam logic [28:0] E_21  = DEF | A2_11 | PCM_ADR | B_LD_PC;
   localparam logic [28:0] E_EA  = DEF | B_SR1 | B_A1 | A2_6 | B_G_MARM | B_LD_MAR;
   localparam logic [28:0] E_27  = DEF | B_G_MDR | B_LD_REG | B_LD_CC;
   localparam logic [28:0] E_23  = DEF | ALU_PASS | B_G_ALU | B_LD_MDR;
   localparam logic [28:0] E_16  = M_OE;
   localparam logic [28:0] E_P1  = DEF | B_LD_LED;

   typedef struct {
      string      nm;
      logic       rst, run, cont, ir5, ben;
      logic [3:0] op;
      logic [28:0] exp;
   } vec_t;

   vec_t        vecs[$];
   logic [28:0] sb[$];
   int          checks = 0;
   int          errors = 0;
   logic        inv_en = 1'b0;

   task automatic add(input string nm, input logic rst, input logic run, input logic cont,
                      input logic [3:0] op, input logic ir5, input logic ben,
                      input logic [28:0] e);
      vec_t v;
      v.nm = nm; v.rst = rst; v.run = run; v.cont = cont;
      v.op = op; v.ir5 = ir5; v.ben = ben; v.exp = e;
      vecs.push_back(v);
   endtask

   // Four rows from S_18 through decode, opcode held throughout
   task automatic fetch(input string nm, input logic [3:0] op, input logic ir5,
                        input logic ben, input logic run);
      add({nm, "_33_1"}, 1'b0, run, 1'b0, op, ir5, ben, E_RD1);
      add({nm, "_33_2"}, 1'b0, run, 1'b0, op, ir5, ben, E_RD2);
      add({nm, "_35"},   1'b0, run, 1'b0, op, ir5, ben, E_35);
      add({nm, "_32"},   1'b0, run, 1'b0, op, ir5, ben, E_32);
   endtask

   task automatic build();
      add("reset",       1, 0, 0, 4'h0, 0, 0, DEF);
      add("halted_idle", 0, 0, 0, 4'h0, 0, 0, DEF);
      add("halted_cont", 0, 0, 1, 4'h0, 0, 0, DEF);
      add("run_s18",     0, 1, 0, 4'h0, 0, 0, E_18);
      // ADD imm
      fetch("add1", 4'b0001, 1, 0, 0);
      add("add1_s01",    0, 0, 0, 4'b0001, 1, 0, E_01 | B_SR2);
      add("add1_s18",    0, 0, 0, 4'b0001, 1, 0, E_18);
      // AND reg
      fetch("and0", 4'b0101, 0, 0, 0);
      add("and0_s05",    0, 0, 0, 4'b0101, 0, 0, E_05);
      add("and0_s18",    0, 0, 0, 4'b0101, 0, 0, E_18);
      // NOT with Run held high (ignored outside HALTED)
      fetch("not", 4'b1001, 0, 0, 1);
      add("not_s09",     0, 1, 0, 4'b1001, 0, 0, E_09);
      add("not_s18",     0, 1, 0, 4'b1001, 0, 0, E_18);
      // BR taken
      fetch("brt", 4'b0000, 0, 1, 0);
      add("brt_s00",     0, 0, 0, 4'b0000, 0, 1, DEF);
      add("brt_s22",     0, 0, 0, 4'b0000, 0, 1, E_22);
      add("brt_s18",     0, 0, 0, 4'b0000, 0, 1, E_18);
      // BR not taken
      fetch("brn", 4'b0000, 0, 0, 0);
      add("brn_s00",     0, 0, 0, 4'b0000, 0, 0, DEF);
      add("brn_s18",     0, 0, 0, 4'b0000, 0, 0, E_18);
      // JMP
      fetch("jmp", 4'b1100, 0, 0, 0);
      add("jmp_s12",     0, 0, 0, 4'b1100, 0, 0, E_12);
      add("jmp_s18",     0, 0, 0, 4'b1100, 0, 0, E_18);
      // JSR
      fetch("jsr", 4'b0100, 0, 0, 0);
      add("jsr_s04",     0, 0, 0, 4'b0100, 0, 0, E_04);
      add("jsr_s21",     0, 0, 0, 4'b0100, 0, 0, E_21);
      add("jsr_s18",     0, 0, 0, 4'b0100, 0, 0, E_18);
      // LDR
      fetch("ldr", 4'b0110, 0, 0, 0);
      add("ldr_s06",     0, 0, 0, 4'b0110, 0, 0, E_EA);
      add("ldr_s25_1",   0, 0, 0, 4'b0110, 0, 0, E_RD1);
      add("ldr_s25_2",   0, 0, 0, 4'b0110, 0, 0, E_RD2);
      add("ldr_s27",     0, 0, 0, 4'b0110, 0, 0, E_27);
      add("ldr_s18",     0, 0, 0, 4'b0110, 0, 0, E_18);
      // STR: two write cycles exactly, then fetch
      fetch("str", 4'b0111, 0, 0, 0);
      add("str_s07",     0, 0, 0, 4'b0111, 0, 0, E_EA);
      add("str_s23",     0, 0, 0, 4'b0111, 0, 0, E_23);
      add("str_s16_1",   0, 0, 0, 4'b0111, 0, 0, E_16);
      add("str_s16_2",   0, 0, 0, 4'b0111, 0, 0, E_16);
      add("str_s18",     0, 0, 0, 4'b0111, 0, 0, E_18);
      // Undefined opcodes fall straight back to fetch
      fetch("nop_f", 4'b1111, 0, 0, 0);
      add("nop_f_s18",   0, 0, 0, 4'b1111, 0, 0, E_18);
      fetch("nop_8", 4'b1000, 0, 0, 0);
      add("nop_8_s18",   0, 0, 0, 4'b1000, 0, 0, E_18);
      // PAUSE handshake with Continue held high for 5 cycles
      fetch("pause", 4'b1101, 0, 0, 0);
      add("pause_p1_a",  0, 0, 0, 4'b1101, 0, 0, E_P1);
      add("pause_p1_b",  0, 0, 0, 4'b1101, 0, 0, E_P1);
      add("pause_p1_c",  0, 0, 0, 4'b1101, 0, 0, E_P1);
      for (int i = 0; i < 5; i++)
         add("pause_p2_hold", 0, 0, 1, 4'b1101, 0, 0, DEF);
      add("pause_s18",   0, 0, 0, 4'b1101, 0, 0, E_18);
      // Reset in the first read cycle of an LDR
      fetch("ldrr", 4'b0110, 0, 0, 0);
      add("ldrr_s06",    0, 0, 0, 4'b0110, 0, 0, E_EA);
      add("ldrr_s25_1",  0, 0, 0, 4'b0110, 0, 0, E_RD1);
      add("ldrr_reset",  1, 0, 0, 4'b0110, 0, 0, DEF);
      add("ldrr_halt",   0, 0, 0, 4'b0110, 0, 0, DEF);
      add("ldrr_halt2",  0, 0, 1, 4'b0110, 0, 0, DEF);
      add("ldrr_run",    0, 1, 0, 4'b0001, 0, 0, E_18);
      fetch("add0", 4'b0001, 0, 0, 0);
      add("add0_s01",    0, 0, 0, 4'b0001, 0, 0, E_01);
      add("add0_s18",    0, 0, 0, 4'b0001, 0, 0, E_18);
      // Reset straight out of a write cycle
      fetch("strr", 4'b0111, 0, 0, 0);
      add("strr_s07",    0, 0, 0, 4'b0111, 0, 0, E_EA);
      add("strr_s23",    0, 0, 0, 4'b0111, 0, 0, E_23);
      add("strr_s16_1",  0, 0, 0, 4'b0111, 0, 0, E_16);
      add("strr_reset",  1, 0, 0, 4'b0111, 0, 0, DEF);
      add("strr_halt",   0, 0, 0, 4'b0111, 0, 0, DEF);
   endtask

   // Bus contention and read/write overlap invariants, every cycle after reset
   always @(negedge Clk) begin
      if (inv_en) begin
         checks++;
         if ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) > 1) begin
            errors++;
            $display("FAIL gate_onehot: gates=%b required at most one high",
                     {GatePC, GateMDR, GateALU, GateMARMUX});
         end
         checks++;
         if (!Mem_OE && !Mem_WE) begin
            errors++;
            $display("FAIL oe_we_overlap: OE=%b WE=%b required not both 0", Mem_OE, Mem_WE);
         end
      end
   end

   initial begin
      logic [28:0] exp;
      Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
      Opcode = 4'h0; IR_5 = 1'b0; BEN = 1'b0;
      build();
      foreach (vecs[i]) begin
         @(negedge Clk);
         Reset    = vecs[i].rst;
         Run      = vecs[i].run;
         Continue = vecs[i].cont;
         Opcode   = vecs[i].op;
         IR_5     = vecs[i].ir5;
         BEN      = vecs[i].ben;
         sb.push_back(vecs[i].exp);
         @(posedge Clk);
         #1;
         inv_en = 1'b1;
         exp = sb.pop_front();
         checks++;
         if (w_out !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %b required %b", vecs[i].nm, i, w_out, exp);
         end
      end
      @(negedge Clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/isdu.md
# isdu

Instruction sequencer/decode unit for the SLC-3 core. It sits directly upstream of the datapath and drives every load enable, bus gate, mux select and ALU op that the datapath consumes. It also drives the active-low SRAM strobes. It steps the fetch, decode and execute microsequence for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, one microstate per clock.

## Interface
Parameters: none.

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock, one reset domain
- Run  in  1  start request, sampled only in HALTED
- Continue  in  1  pause-release request, sampled only in PAUSE_IR1/PAUSE_IR2
- Opcode  in  4  IR[15:12]
- IR_5  in  1  IR[5], immediate select for ADD/AND
- BEN  in  1  branch-enable register output
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle
- SR2MUX  out  1  0=SR2 register, 1=SEXT(IR[4:0])
- ADDR1MUX  out  1  0=PC, 1=SR1
- MARMUX, DRMUX, SR1MUX  out  1 each  DRMUX: 0=IR[11:9], 1=R7; SR1MUX: 0=IR[11:9], 1=IR[8:6]
- MIO_EN  out  1  1=MDR loads from memory, 0=from bus
- PCMUX  out  2  00=PC+1, 01=bus, 10=address adder
- ADDR2MUX  out  2  00=0, 01=SEXT6, 10=SEXT9, 11=SEXT11
- ALUK  out  2  00=ADD, 01=AND, 10=NOT, 11=PASS A
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low

## Operation
- Moore machine. The state register is updated on the rising edge of Clk. Next state and all outputs are combinational from the current state (and from IR_5 for SR2MUX).
- Default control word: all loads, gates and selects 0; all Mem_* 1.
- States and the non-default outputs asserted in each:
  - HALTED: defaults only. Run=1 -> S_18; otherwise stay.
  - S_18: GatePC, LD_MAR, PCMUX=00, LD_PC. -> S_33_1.
  - S_33_1: Mem_CE=Mem_UB=Mem_LB=Mem_OE=0, MIO_EN=1. -> S_33_2.
  - S_33_2: same as S_33_1, plus LD_MDR. -> S_35.
  - S_35: GateMDR, LD_IR. -> S_32.
  - S_32: LD_BEN. Branches on Opcode:
    - 0001 -> S_01 (ADD), 0101 -> S_05 (AND), 1001 -> S_09 (NOT)
    - 0000 -> S_00 (BR), 1100 -> S_12 (JMP), 0100 -> S_04 (JSR)
    - 0110 -> S_06 (LDR), 0111 -> S_07 (STR), 1101 -> PAUSE_IR1
    - any other opcode -> S_18 (executes as NOP)
  - S_01 / S_05: SR1MUX=1, SR2MUX=IR_5, ALUK=00 / 01, GateALU, LD_REG, LD_CC, DRMUX=0. -> S_18.
  - S_09: SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC. -> S_18.
  - S_00: BEN=1 -> S_22; BEN=0 -> S_18.
  - S_22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC. -> S_18.
  - S_12: SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC. -> S_18.
  - S_04: GatePC, DRMUX=1, LD_REG. -> S_21.
  - S_21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC. -> S_18.
  - S_06 / S_07: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR. S_06 -> S_25_1; S_07 -> S_23.
  - S_25_1, S_25_2: same as S_33_1 and S_33_2. S_25_2 -> S_27.
  - S_27: GateMDR, LD_REG, LD_CC, DRMUX=0. -> S_18.
  - S_23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR. -> S_16_1.
  - S_16_1, S_16_2: Mem_CE=Mem_UB=Mem_LB=Mem_WE=0, Mem_OE=1. S_16_2 -> S_18.
  - PAUSE_IR1: LD_LED. Continue=1 -> PAUSE_IR2; otherwise stay.
  - PAUSE_IR2: Continue=0 -> S_18; otherwise stay.
- Invariants: Mem_OE and Mem_WE are never low together, and at most one Gate* is high in any cycle.

## Timing
- Reset=1 at an edge forces HALTED on that edge from any state, including mid-memory access. While in HALTED all outputs hold the default word, so every Mem_* reads 1 after reset.
- Run is ignored outside HALTED. There is no return to HALTED except through Reset.
- Latency is counted from entering S_18 to re-entering S_18:
  - Fetch plus decode: 5 cycles.
  - ADD, AND, NOT, JMP, BR not taken: 6 cycles.
  - BR taken, JSR: 7 cycles.
  - LDR, STR: 9 cycles.
- A PAUSE requires Continue to go high and then return low before fetch resumes. Continue held high stalls in PAUSE_IR2 indefinitely.
- Each memory access holds its strobes stable for exactly 2 consecutive cycles.

## Test plan
- Reset pulse, then Run=1 for 1 cycle -> HALTED, then S_18 on the next edge; LD_MAR=LD_PC=GatePC=1 in that cycle; all Mem_*=1 during reset.
- Opcode=0001, IR_5=1 -> S_32 is followed by S_01 with SR2MUX=1, ALUK=00, LD_REG=LD_CC=1; S_18 is re-entered 6 cycles after the previous S_18.
- Opcode=0000 with BEN=1, then BEN=0 -> S_22 (PCMUX=10, ADDR2MUX=10, LD_PC=1) in the first case; direct return to S_18 in the second.
- Opcode=0111 -> S_23 shows MIO_EN=0, LD_MDR=1; then Mem_WE=0 and Mem_OE=1 for exactly 2 cycles; loop length is 9 cycles.
- Opcode=1101 -> LD_LED=1 held while Continue=0. Continue=1 for 5 cycles -> state stays PAUSE_IR2. Continue=0 -> S_18.
- Reset asserted during S_25_1 of an LDR -> HALTED on the next edge; Mem_CE/Mem_OE return to 1; LD_REG is never asserted.
